// File: rtl/prog_sequencer.sv
`default_nettype none
// prog_sequencer: banked program store with edit, bank clear, single-step, slow-run and full-speed run.
// Revision 1.0 - initial release.

module prog_sequencer #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter int                NUM_BANKS = 4,
  parameter logic [DATA_W-1:0] HALT_CODE = 8'h32,
  parameter int                SLOW_DIV  = 4,
  localparam int               BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rstROM,
  input  logic              edit,
  input  logic [ADDR_W-1:0] unit,
  input  logic [DATA_W-1:0] code,
  input  logic              send,
  input  logic [BANK_W-1:0] program_sel,
  input  logic              NEXT,
  input  logic              RUN,
  input  logic              SPEEDRUN,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc,
  output logic [BANK_W-1:0] bank,
  output logic              step,
  output logic              halted,
  output logic              running,
  output logic              busy
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam int                DIV_W     = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SLOW_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EDIT  = 3'd1,
    S_CLEAR = 3'd2,
    S_RUN   = 3'd3,
    S_SPEED = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, clr_q, clr_d, pc_next;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              halted_q, halted_d, busy_q, busy_d;
  logic [4:0]        cmd_q, cmd_d, cmd_rise;
  logic              want_step, step_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_q [NUM_BANKS][DEPTH];

  // Bit order: {rstROM, SPEEDRUN, RUN, NEXT, send}
  assign cmd_d    = {rstROM, SPEEDRUN, RUN, NEXT, send};
  assign cmd_rise = cmd_d & ~cmd_q;
  assign instr    = mem_q[bank_q][pc_q];
  assign pc_next  = pc_load ? pc_load_val : pc_q + ADDR_W'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    bank_d    = bank_q;
    div_d     = div_q;
    halted_d  = halted_q;
    busy_d    = busy_q;
    clr_d     = clr_q;
    want_step = 1'b0;
    step_d    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = unit;
    mem_wdata = code;

    if (cmd_rise[4] && state_q != S_CLEAR) begin
      state_d  = S_CLEAR;
      busy_d   = 1'b1;
      halted_d = 1'b0;
      clr_d    = '0;
      if (state_q == S_IDLE || state_q == S_EDIT) bank_d = program_sel;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          bank_d = program_sel;
          if (edit)             state_d = S_EDIT;
          else if (cmd_rise[3]) state_d = S_SPEED;
          else if (cmd_rise[2]) begin
            state_d = S_RUN;
            div_d   = '0;
          end else if (cmd_rise[1]) want_step = 1'b1;
        end
        S_EDIT: begin
          bank_d = program_sel;
          mem_we = cmd_rise[0];
          if (!edit) begin
            state_d = S_IDLE;
            pc_d    = '0;
          end
        end
        S_RUN: begin
          if (cmd_rise[1]) state_d = S_IDLE;
          else if (div_q == DIV_LAST) begin
            div_d     = '0;
            want_step = 1'b1;
          end else div_d = div_q + DIV_W'(1);
        end
        S_SPEED: begin
          if (cmd_rise[1]) state_d = S_IDLE;
          else             want_step = 1'b1;
        end
        S_HALT: begin
          if (edit) begin
            state_d  = S_EDIT;
            pc_d     = '0;
            halted_d = 1'b0;
          end
        end
        S_CLEAR: begin
          mem_we    = 1'b1;
          mem_addr  = clr_q;
          mem_wdata = '0;
          if (clr_q == ADDR_LAST) begin
            state_d = S_IDLE;
            pc_d    = '0;
            busy_d  = 1'b0;
            clr_d   = '0;
          end else clr_d = clr_q + ADDR_W'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A step landing on the halt opcode is swallowed and parks the sequencer.
    if (want_step) begin
      if (instr == HALT_CODE) begin
        state_d  = S_HALT;
        halted_d = 1'b1;
      end else begin
        step_d = 1'b1;
        pc_d   = pc_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      bank_q   <= '0;
      div_q    <= '0;
      halted_q <= 1'b0;
      busy_q   <= 1'b0;
      clr_q    <= '0;
      cmd_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      bank_q   <= bank_d;
      div_q    <= div_d;
      halted_q <= halted_d;
      busy_q   <= busy_d;
      clr_q    <= clr_d;
      cmd_q    <= cmd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[bank_q][mem_addr] <= mem_wdata;
  end

  assign pc      = pc_q;
  assign bank    = bank_q;
  assign step    = step_d & ~rst;
  assign halted  = halted_q;
  assign busy    = busy_q;
  assign running = (state_q == S_RUN) || (state_q == S_SPEED);

endmodule

`default_nettype wire

// File: tb/tb_prog_sequencer.sv
`default_nettype none
// tb_prog_sequencer: directed, table-driven checks of prog_sequencer (default and ADDR_W=4 instances).
// Revision 1.0 - initial release.

module tb_prog_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_rom = 1'b0, edit = 1'b0, send = 1'b0;
  logic       next_c = 1'b0, run_c = 1'b0, speed_c = 1'b0, pc_load = 1'b0;
  logic [7:0] unit = '0, code = '0, pc_load_val = '0;
  logic [1:0] program_sel = '0;
  logic [7:0] instr, pc;
  logic [1:0] bank;
  logic       step, halted, running, busy;

  logic       rst_rom4 = 1'b0, next4 = 1'b0, pc_load4 = 1'b0;
  logic [3:0] pc_load_val4 = '0;
  logic [7:0] instr4;
  logic [3:0] pc4;
  logic [1:0] bank4;
  logic       step4, halted4, running4, busy4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       nxt;
    logic       ld;
    logic [7:0] val;
    logic       exp_step;
    logic [7:0] exp_pc;
  } vec_t;
  vec_t tbl[$];

  prog_sequencer dut (
    .clk(clk), .rst(rst), .rstROM(rst_rom), .edit(edit), .unit(unit), .code(code),
    .send(send), .program_sel(program_sel), .NEXT(next_c), .RUN(run_c), .SPEEDRUN(speed_c),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .instr(instr), .pc(pc), .bank(bank),
    .step(step), .halted(halted), .running(running), .busy(busy)
  );

  prog_sequencer #(.ADDR_W(4)) dut4 (
    .clk(clk), .rst(rst), .rstROM(rst_rom4), .edit(1'b0), .unit(4'd0), .code(8'd0),
    .send(1'b0), .program_sel(2'd0), .NEXT(next4), .RUN(1'b0), .SPEEDRUN(1'b0),
    .pc_load(pc_load4), .pc_load_val(pc_load_val4), .instr(instr4), .pc(pc4), .bank(bank4),
    .step(step4), .halted(halted4), .running(running4), .busy(busy4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic add(input logic n, input logic l, input logic [7:0] v,
                     input logic s, input logic [7:0] p);
    tbl.push_back('{n, l, v, s, p});
  endtask

  task automatic write_word(input logic [7:0] a, input logic [7:0] d);
    unit = a; code = d; send = 1'b1;
    tick();
    send = 1'b0;
    tick();
  endtask

  task automatic read_at(input string name, input logic [7:0] a, input logic [7:0] exp);
    next_c = 1'b1; pc_load = 1'b1; pc_load_val = a;
    tick();
    next_c = 1'b0; pc_load = 1'b0;
    #1 chk(name, instr, exp);
    tick();
  endtask

  // Counts consecutive busy cycles starting at the current cycle; stops at the first idle cycle.
  task automatic count_busy(output int n, output int n4);
    n = 0; n4 = 0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (busy4) n4++;
      if (busy) n++;
      else if (n > 0) break;
      tick();
    end
  endtask

  initial begin
    int n, n4;

    // reset state
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_pc", pc, 0);       chk("rst_bank", bank, 0);   chk("rst_step", step, 0);
    chk("rst_halted", halted, 0); chk("rst_running", running, 0); chk("rst_busy", busy, 0);
    chk("rst_pc4", pc4, 0);     chk("rst_bank4", bank4, 0); chk("rst_halted4", halted4, 0);
    chk("rst_running4", running4, 0);
    tick();

    // clear bank 0 of both instances: 256 and 16 busy cycles
    rst_rom = 1'b1; rst_rom4 = 1'b1;
    tick();
    rst_rom = 1'b0; rst_rom4 = 1'b0;
    count_busy(n, n4);
    chk("clear_busy_cycles", n, 256);
    chk("clear_busy_cycles4", n4, 16);
    chk("clear_pc", pc, 0);
    chk("clear_instr", instr, 0);
    chk("clear_instr4", instr4, 0);
    tick();

    // IDLE single-step / pc_load / wrap table
    add(1,0,8'h00,1,8'h00); add(0,0,8'h00,0,8'h01); add(1,0,8'h00,1,8'h01); add(0,0,8'h00,0,8'h02);
    add(1,0,8'h00,1,8'h02); add(0,0,8'h00,0,8'h03); add(1,0,8'h00,1,8'h03);
    for (int i = 0; i < 9; i++) add(1,0,8'h00,0,8'h04);
    add(0,0,8'h00,0,8'h04); add(1,1,8'h80,1,8'h04); add(0,0,8'h00,0,8'h80);
    add(1,1,8'hFF,1,8'h80); add(0,0,8'h00,0,8'hFF); add(1,0,8'h00,1,8'hFF);
    add(0,0,8'h00,0,8'h00); add(1,0,8'h00,1,8'h00); add(0,1,8'h55,0,8'h01);
    add(0,0,8'h00,0,8'h01);
    foreach (tbl[i]) begin
      next_c = tbl[i].nxt; pc_load = tbl[i].ld; pc_load_val = tbl[i].val;
      #1;
      chk($sformatf("tbl%0d_step", i), step, tbl[i].exp_step);
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].exp_pc);
      tick();
    end
    next_c = 1'b0; pc_load = 1'b0;

    // ADDR_W=4 wrap and jump
    next4 = 1'b1; pc_load4 = 1'b1; pc_load_val4 = 4'd15;
    tick();
    next4 = 1'b0; pc_load4 = 1'b0;
    #1 chk("w4_pc15", pc4, 15);
    tick();
    next4 = 1'b1;
    #1 chk("w4_step", step4, 1);
    tick();
    next4 = 1'b0;
    #1 chk("w4_wrap", pc4, 0);
    tick();
    next4 = 1'b1; pc_load4 = 1'b1; pc_load_val4 = 4'd9;
    tick();
    next4 = 1'b0; pc_load4 = 1'b0;
    #1 chk("w4_load9", pc4, 9);
    tick();

    // program bank 0: 00, 07, HALT
    edit = 1'b1;
    tick();
    write_word(8'd1, 8'h07);
    write_word(8'd2, 8'h32);
    edit = 1'b0;
    tick();
    #1 chk("edit_exit_pc", pc, 0);
    tick();

    // slow run: steps at +4 and +8, halt at pc 2
    run_c = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk($sformatf("run_k%0d_step", k), step, (k == 4 || k == 8));
      if (k == 2) chk("run_running", running, 1);
      if (k == 6) chk("run_pc_mid", pc, 1);
      tick();
      run_c = 1'b0;
    end
    #1;
    chk("run_halted", halted, 1); chk("run_pc_end", pc, 2); chk("run_running_end", running, 0);
    edit = 1'b1;
    tick();
    edit = 1'b0;
    tick();
    #1 chk("halt_exit_halted", halted, 0); chk("halt_exit_pc", pc, 0);
    tick();

    // full-speed run with a bank request mid-run
    speed_c = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("spd_k%0d_step", k), step, (k == 1 || k == 2));
      if (k == 1) chk("spd_running", running, 1);
      tick();
      speed_c = 1'b0;
      program_sel = 2'd1;
    end
    #1;
    chk("spd_halted", halted, 1); chk("spd_running_end", running, 0);
    chk("spd_pc_end", pc, 2);     chk("spd_bank_held", bank, 0);
    program_sel = 2'd0;
    edit = 1'b1;
    tick();
    edit = 1'b0;
    tick();

    // NEXT edge pauses a speed run without stepping
    speed_c = 1'b1;
    tick();
    speed_c = 1'b0; next_c = 1'b1;
    #1 chk("pause_step", step, 0);
    tick();
    next_c = 1'b0;
    #1 chk("pause_running", running, 0); chk("pause_pc", pc, 0);
    tick();

    // rstROM wins over edit and SPEEDRUN in the same cycle; clears bank 2
    program_sel = 2'd2;
    tick();
    #1 chk("bank_sel2", bank, 2);
    rst_rom = 1'b1; edit = 1'b1; speed_c = 1'b1;
    tick();
    rst_rom = 1'b0; edit = 1'b0; speed_c = 1'b0;
    #1 chk("prio_busy", busy, 1); chk("prio_running", running, 0);
    count_busy(n, n4);
    chk("clear2_busy_cycles", n, 256);
    tick();
    read_at("b2_zero_0", 8'd0, 8'h00);
    read_at("b2_zero_255", 8'd255, 8'h00);

    // partial clear aborted by rst after 100 words
    edit = 1'b1;
    tick();
    write_word(8'd0, 8'h11);   write_word(8'd99, 8'h11);
    write_word(8'd100, 8'hA5); write_word(8'd255, 8'hA5);
    edit = 1'b0;
    tick();
    rst_rom = 1'b1;
    tick();
    rst_rom = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk("abort_busy", busy, 0); chk("abort_bank", bank, 0);
    tick();
    tick();
    read_at("abort_0", 8'd0, 8'h00);
    read_at("abort_99", 8'd99, 8'h00);
    read_at("abort_100", 8'd100, 8'hA5);
    read_at("abort_255", 8'd255, 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
